// File: rtl/inq_pkg.sv
// Shared constants, state encoding and default thresholds for the input quantizer/packer.
package inq_pkg;

  localparam int unsigned MAX_FEATURES = 16;
  localparam int unsigned RAW_W        = 8;
  localparam int unsigned Q_W          = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  // Indexed [feature][sel]; sel 0/1/2 are t0/t1/t2, identical for every feature.
  localparam logic [MAX_FEATURES-1:0][2:0][RAW_W-1:0] DEF_THRESH =
    {MAX_FEATURES{8'd192, 8'd128, 8'd64}};

endpackage

// File: rtl/input_quant_packer_if.sv
// Raw-sample input stream plus packed-vector output stream of the quantizer/packer.
interface input_quant_packer_if #(
  parameter int unsigned NUM_FEATURES = inq_pkg::MAX_FEATURES
);

  logic                                   s_valid;
  logic                                   s_ready;
  logic [inq_pkg::RAW_W-1:0]              s_data;
  logic                                   s_last;
  logic                                   m_valid;
  logic                                   m_ready;
  logic [NUM_FEATURES*inq_pkg::Q_W-1:0]   m_data;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data
  );

endinterface

// File: rtl/inq_quantize.sv
// Combinational 2-bit quantizer: code counts how many of t0/t1/t2 the sample reaches.
module inq_quantize
  import inq_pkg::*;
(
  input  logic [RAW_W-1:0] i_x,
  input  logic [RAW_W-1:0] i_t0,
  input  logic [RAW_W-1:0] i_t1,
  input  logic [RAW_W-1:0] i_t2,
  output logic [Q_W-1:0]   o_code_c
);

  assign o_code_c = Q_W'(i_x >= i_t0) + Q_W'(i_x >= i_t1) + Q_W'(i_x >= i_t2);

endmodule

// File: rtl/input_quant_packer.sv
// Quantizes one raw feature per beat and packs a whole frame into the layer-0 input vector.
// Build option INQ_THRESH_PROG_EN adds run-time programmable thresholds (cfg_* ports).
module input_quant_packer
  import inq_pkg::*;
#(
  parameter int unsigned NUM_FEATURES = MAX_FEATURES  // must be 2..MAX_FEATURES
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input_quant_packer_if.slave             bus,
`ifdef INQ_THRESH_PROG_EN
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_FEATURES)-1:0] cfg_feat,
  input  logic [1:0]                      cfg_sel,
  input  logic [RAW_W-1:0]                cfg_data,
`endif
  output logic                            err,
  output logic [15:0]                     frame_cnt
);

  localparam int unsigned      IDX_W    = $clog2(NUM_FEATURES);
  localparam int unsigned      PACK_W   = NUM_FEATURES * Q_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  state_e                                 r_state, w_state_nxt;
  logic [IDX_W-1:0]                       r_idx, w_idx_nxt;
  logic [PACK_W-1:0]                      r_pack, w_pack_nxt, w_slot;
  logic [PACK_W-1:0]                      r_m_data, w_m_data_nxt;
  logic                                   r_m_valid, w_m_valid_nxt;
  logic                                   r_s_ready, w_s_ready_nxt;
  logic                                   r_err, w_err_nxt;
  logic [15:0]                            r_frame_cnt, w_frame_cnt_nxt;
  logic                                   w_accept;
  logic [Q_W-1:0]                         w_code;
  logic [NUM_FEATURES-1:0][2:0][RAW_W-1:0] w_thr;

`ifdef INQ_THRESH_PROG_EN
  logic [NUM_FEATURES-1:0][2:0][RAW_W-1:0] r_thr;

  // Writes land at the clock edge, so a beat quantized in the write cycle still sees the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_thr <= DEF_THRESH[NUM_FEATURES-1:0];
    end else if (cfg_we && (cfg_sel != 2'd3) && (32'(cfg_feat) < NUM_FEATURES)) begin
      r_thr[cfg_feat][cfg_sel] <= cfg_data;
    end
  end

  assign w_thr = r_thr;
`else
  assign w_thr = DEF_THRESH[NUM_FEATURES-1:0];
`endif

  inq_quantize u_quantize (
    .i_x      (bus.s_data),
    .i_t0     (w_thr[r_idx][0]),
    .i_t1     (w_thr[r_idx][1]),
    .i_t2     (w_thr[r_idx][2]),
    .o_code_c (w_code)
  );

  // Pack register with the current beat's code dropped into slot r_idx.
  always_comb begin
    w_slot = r_pack;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (r_idx == IDX_W'(i)) w_slot[i*Q_W +: Q_W] = w_code;
    end
  end

  assign w_accept = bus.s_valid && r_s_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_pack_nxt      = r_pack;
    w_m_data_nxt    = r_m_data;
    w_m_valid_nxt   = r_m_valid;
    w_err_nxt       = 1'b0;
    w_frame_cnt_nxt = r_frame_cnt;

    unique case (r_state)
      COLLECT: begin
        if (w_accept) begin
          w_pack_nxt = w_slot;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            if (bus.s_last) begin
              w_m_data_nxt  = w_slot;
              w_m_valid_nxt = 1'b1;
              w_state_nxt   = HOLD;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = DRAIN;
            end
          end else if (bus.s_last) begin
            w_err_nxt = 1'b1;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      HOLD: begin
        if (r_m_valid && bus.m_ready) begin
          w_m_valid_nxt   = 1'b0;
          w_frame_cnt_nxt = r_frame_cnt + 16'd1;
          w_state_nxt     = COLLECT;
        end
      end
      DRAIN: begin
        if (w_accept && bus.s_last) begin
          w_idx_nxt   = '0;
          w_state_nxt = COLLECT;
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = COLLECT;
      end
    endcase

    // Registered ready: follows the next state, never m_ready combinationally.
    w_s_ready_nxt = (w_state_nxt != HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_idx       <= '0;
      r_pack      <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_s_ready   <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_pack      <= w_pack_nxt;
      r_m_data    <= w_m_data_nxt;
      r_m_valid   <= w_m_valid_nxt;
      r_s_ready   <= w_s_ready_nxt;
      r_err       <= w_err_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign err         = r_err;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_input_quant_packer.sv
// Directed plus randomized frames for input_quant_packer (4 features), checked against a
// frame-level reference model of quantization, framing errors and delivery count.
module tb_input_quant_packer;
  import inq_pkg::*;

  localparam int unsigned NF = 4;
  localparam int unsigned PW = NF * Q_W;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        err;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  input_quant_packer_if #(.NUM_FEATURES(NF)) bus ();

`ifdef INQ_THRESH_PROG_EN
  logic             cfg_we;
  logic [1:0]       cfg_feat;
  logic [1:0]       cfg_sel;
  logic [RAW_W-1:0] cfg_data;
`endif

  input_quant_packer #(.NUM_FEATURES(NF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
`ifdef INQ_THRESH_PROG_EN
    .cfg_we    (cfg_we),
    .cfg_feat  (cfg_feat),
    .cfg_sel   (cfg_sel),
    .cfg_data  (cfg_data),
`endif
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  int          n_pass = 0;
  int          n_chk  = 0;
  int          thr [NF][3];
  int          codes [NF];
  int          m_idx;
  bit          m_drain;
  bit          last_mv;
  logic [PW-1:0] exp_data;
  int          exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
  endtask

  // Code is simply how many of the feature's thresholds the sample reaches.
  function automatic int ref_code(input int x, input int f);
    int c;
    c = 0;
    for (int s = 0; s < 3; s++) if (x >= thr[f][s]) c++;
    return c;
  endfunction

  function automatic logic [7:0] rand_raw(input int f);
    int v;
    if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 255));
    else v = thr[f][$urandom_range(0, 2)] + int'($urandom_range(0, 2)) - 1;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  task automatic beat(input logic [7:0] d, input logic last);
    bit exp_err;
    bit exp_mv;
    int w;
    exp_err = 1'b0;
    exp_mv  = 1'b0;
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    w = 0;
    while (bus.s_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("s_ready_wait", 32'(bus.s_ready), 32'd1);
    if (m_drain) begin
      if (last) m_drain = 1'b0;
    end else begin
      codes[m_idx] = ref_code(int'(d), m_idx);
      if (m_idx == NF - 1) begin
        if (last) begin
          exp_mv = 1'b1;
          for (int i = 0; i < NF; i++) exp_data[2*i +: 2] = 2'(codes[i]);
        end else begin
          exp_err = 1'b1;
          m_drain = 1'b1;
        end
        m_idx = 0;
      end else if (last) begin
        exp_err = 1'b1;
        m_idx   = 0;
      end else begin
        m_idx++;
      end
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    last_mv = exp_mv;
    chk("err", 32'(err), 32'(exp_err));
    chk("m_valid", 32'(bus.m_valid), 32'(exp_mv));
    if (exp_mv) chk("m_data", 32'(bus.m_data), 32'(exp_data));
  endtask

  task automatic deliver(input int stall);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.m_valid), 32'd1);
      chk("hold_data", 32'(bus.m_data), 32'(exp_data));
      chk("hold_s_ready", 32'(bus.s_ready), 32'd0);
    end
    @(negedge clk);
    bus.m_ready = 1'b1;
    chk("pre_valid", 32'(bus.m_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.m_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) & 32'hFFFF;
    chk("post_valid", 32'(bus.m_valid), 32'd0);
    chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    chk("post_s_ready", 32'(bus.s_ready), 32'd1);
  endtask

  task automatic rand_frame_deliver(input int stall);
    for (int b = 0; b < NF; b++) beat(rand_raw(b), b == NF - 1);
    if (last_mv) deliver(stall);
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
  endtask

`ifdef INQ_THRESH_PROG_EN
  task automatic cfg_write(input int f, input int sel, input int val);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_feat = 2'(f);
    cfg_sel  = 2'(sel);
    cfg_data = 8'(val);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (sel < 3) thr[f][sel] = val;
  endtask
`endif

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    rst_n       = 1'b0;
`ifdef INQ_THRESH_PROG_EN
    cfg_we   = 1'b0;
    cfg_feat = '0;
    cfg_sel  = '0;
    cfg_data = '0;
`endif
    for (int f = 0; f < NF; f++) begin
      thr[f][0] = 64;
      thr[f][1] = 128;
      thr[f][2] = 192;
    end
    m_idx    = 0;
    m_drain  = 1'b0;
    exp_cnt  = 0;
    exp_data = '0;

    // Power-on reset, then release
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_s_ready", 32'(bus.s_ready), 32'd1);

    // Golden frame, accepted immediately
    beat(8'd0, 1'b0);
    beat(8'd64, 1'b0);
    beat(8'd191, 1'b0);
    beat(8'd255, 1'b1);
    chk("golden", 32'(bus.m_data), 32'h0000_00E4);
    deliver(0);

    // Same frame, downstream stalls five cycles
    beat(8'd0, 1'b0);
    beat(8'd64, 1'b0);
    beat(8'd191, 1'b0);
    beat(8'd255, 1'b1);
    deliver(5);

    // Short frame: last on beat 2
    beat(rand_raw(0), 1'b0);
    beat(rand_raw(1), 1'b1);
    rand_frame_deliver(1);

    // Long frame: last only on beat 7
    for (int b = 0; b < 7; b++) beat(rand_raw(b % NF), b == 6);
    rand_frame_deliver(0);

    // Reset asserted while beat 3 is offered
    beat(rand_raw(0), 1'b0);
    beat(rand_raw(1), 1'b0);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = rand_raw(2);
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    m_idx   = 0;
    m_drain = 1'b0;
    exp_cnt = 0;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rerelease_s_ready", 32'(bus.s_ready), 32'd1);
    rand_frame_deliver(2);

    // Randomized mix of good, short and long frames
    for (int fr = 0; fr < 24; fr++) begin
      int kind;
      int len;
      kind = int'($urandom_range(0, 7));
      if (kind == 0) len = int'($urandom_range(1, NF - 1));
      else if (kind == 1) len = int'($urandom_range(NF + 1, NF + 4));
      else len = NF;
      for (int b = 0; b < len; b++) beat(rand_raw(b % NF), b == len - 1);
      if (last_mv) deliver(int'($urandom_range(0, 3)));
    end

`ifdef INQ_THRESH_PROG_EN
    // Programmed t0 of feature 0, plus an ignored sel=3 write
    cfg_write(0, 0, 10);
    cfg_write(1, 3, 0);
    beat(8'd5, 1'b0);
    for (int b = 1; b < NF; b++) beat(rand_raw(b), b == NF - 1);
    chk("prog_code_5", 32'(bus.m_data[1:0]), 32'd0);
    deliver(0);
    beat(8'd10, 1'b0);
    for (int b = 1; b < NF; b++) beat(rand_raw(b), b == NF - 1);
    chk("prog_code_10", 32'(bus.m_data[1:0]), 32'd1);
    deliver(0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
